// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: two-requester duty ramp controller driving pwm duty_need/duty_gap
module pwm_ramp_ctrl #(
   parameter int DUTY_W   = 20,
   parameter int GAP_W    = 10,
   parameter int TICK_DIV = 1000,
   parameter int TICK_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DUTY_W-1:0] req0_target,
   input  logic [GAP_W-1:0]  req0_step,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DUTY_W-1:0] req1_target,
   input  logic [GAP_W-1:0]  req1_step,
   output logic              req1_ready,
   output logic [DUTY_W-1:0] duty_need,
   output logic [GAP_W-1:0]  duty_gap,
   output logic              busy,
   output logic              done,
   output logic              owner
);
   typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;
   state_t state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d, tgt_q, tgt_d, step_res, acc_tgt;
   logic [DUTY_W:0] sum;
   logic [GAP_W-1:0] gap_q, gap_d, acc_stp;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic owner_q, owner_d, acc0, acc1, acc, tick_hit;
   assign req1_ready = !rst && (state_q == IDLE || (state_q == RAMP && !owner_q));
   assign req0_ready = !rst && state_q == IDLE && !req1_valid;
   assign acc1 = req1_valid && req1_ready;
   assign acc0 = req0_valid && req0_ready;
   assign acc = acc0 || acc1;
   assign acc_tgt = acc1 ? req1_target : req0_target;
   assign acc_stp = acc1 ? req1_step : req0_step;
   assign tick_hit = tick_q == TICK_W'(TICK_DIV - 1);
   assign sum = {1'b0, duty_q} + (DUTY_W + 1)'(gap_q);
   assign step_res = (tgt_q > duty_q)
      ? ((sum > {1'b0, tgt_q}) ? tgt_q : sum[DUTY_W-1:0])
      : (((duty_q - tgt_q) <= DUTY_W'(gap_q)) ? tgt_q : duty_q - DUTY_W'(gap_q));
   assign duty_need = duty_q;
   assign duty_gap = gap_q;
   assign busy = state_q == RAMP;
   assign done = state_q == DONE;
   assign owner = owner_q;
   // next state: acceptance (incl. preemption) wins over a tick step in the same cycle
   always_comb begin
      state_d = state_q;
      duty_d = duty_q;
      tgt_d = tgt_q;
      gap_d = gap_q;
      owner_d = owner_q;
      tick_d = tick_q;
      if (acc) begin
         tgt_d = acc_tgt;
         gap_d = (acc_stp == '0) ? GAP_W'(1) : acc_stp;
         owner_d = acc1;
         tick_d = '0;
         state_d = (acc_tgt == duty_q) ? DONE : RAMP;
      end else if (state_q == RAMP) begin
         tick_d = tick_hit ? '0 : tick_q + 1'b1;
         if (tick_hit) begin
            duty_d = step_res;
            state_d = (step_res == tgt_q) ? DONE : RAMP;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         duty_q <= '0;
         tgt_q <= '0;
         gap_q <= GAP_W'(1);
         owner_q <= 1'b0;
         tick_q <= '0;
      end else begin
         state_q <= state_d;
         duty_q <= duty_d;
         tgt_q <= tgt_d;
         gap_q <= gap_d;
         owner_q <= owner_d;
         tick_q <= tick_d;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed table-driven bench for pwm_ramp_ctrl with TICK_DIV=4
module tb_pwm_ramp_ctrl;
   logic clk, rst;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [19:0] req0_target, req1_target, duty_need;
   logic [9:0] req0_step, req1_step, duty_gap;
   logic busy, done, owner;
   int checks = 0;
   int errors = 0;
   logic [19:0] cur;

   typedef struct {
      bit who;
      logic [19:0] tgt;
      logic [9:0] stp;
      logic [9:0] gap;
      int n;
      logic [3:0][19:0] seq;
   } vec_t;
   vec_t vecs [5];

   pwm_ramp_ctrl #(.DUTY_W(20), .GAP_W(10), .TICK_DIV(4), .TICK_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_target(req0_target), .req0_step(req0_step), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_target(req1_target), .req1_step(req1_step), .req1_ready(req1_ready),
      .duty_need(duty_need), .duty_gap(duty_gap), .busy(busy), .done(done), .owner(owner)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // call at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input bit who, input logic [19:0] t, input logic [9:0] s);
      int k = 0;
      while (((who ? req1_ready : req0_ready) !== 1'b1) && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("ready_before_issue", {31'd0, who ? req1_ready : req0_ready}, 1);
      if (who) begin
         req1_valid = 1; req1_target = t; req1_step = s;
      end else begin
         req0_valid = 1; req0_target = t; req0_step = s;
      end
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic pulse_reset();
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst_duty", {12'd0, duty_need}, 0);
   endtask

   task automatic run_vec(input vec_t v);
      issue(v.who, v.tgt, v.stp);
      check("vec_owner", {31'd0, owner}, {31'd0, v.who});
      check("vec_gap", {22'd0, duty_gap}, {22'd0, v.gap});
      check("vec_start_duty", {12'd0, duty_need}, {12'd0, cur});
      check("vec_busy_start", {31'd0, busy}, (v.n == 0) ? 0 : 1);
      check("vec_done_start", {31'd0, done}, (v.n == 0) ? 1 : 0);
      for (int i = 0; i < v.n; i++) begin
         repeat (3) @(negedge clk);
         check("vec_hold", {12'd0, duty_need}, {12'd0, cur});
         @(negedge clk);
         cur = v.seq[i];
         check("vec_step", {12'd0, duty_need}, {12'd0, cur});
         check("vec_done", {31'd0, done}, (i == v.n - 1) ? 1 : 0);
      end
      @(negedge clk);
      check("vec_done_once", {31'd0, done}, 0);
      check("vec_idle_busy", {31'd0, busy}, 0);
      check("vec_idle_gap", {22'd0, duty_gap}, {22'd0, v.gap});
   endtask

   initial begin
      vecs[0] = '{who: 0, tgt: 20, stp: 5, gap: 5, n: 4, seq: {20'd20, 20'd15, 20'd10, 20'd5}};
      vecs[1] = '{who: 0, tgt: 10, stp: 3, gap: 3, n: 4, seq: {20'd10, 20'd11, 20'd14, 20'd17}};
      vecs[2] = '{who: 1, tgt: 0, stp: 10, gap: 10, n: 1, seq: {20'd0, 20'd0, 20'd0, 20'd0}};
      vecs[3] = '{who: 0, tgt: 3, stp: 0, gap: 1, n: 3, seq: {20'd0, 20'd3, 20'd2, 20'd1}};
      vecs[4] = '{who: 0, tgt: 3, stp: 7, gap: 7, n: 0, seq: {20'd0, 20'd0, 20'd0, 20'd0}};
      rst = 1;
      req0_valid = 1; req0_target = 50; req0_step = 5;
      req1_valid = 1; req1_target = 0; req1_step = 2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_duty", {12'd0, duty_need}, 0);
      check("rst_gap", {22'd0, duty_gap}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_owner", {31'd0, owner}, 0);
      check("rst_ready0", {31'd0, req0_ready}, 0);
      check("rst_ready1", {31'd0, req1_ready}, 0);
      rst = 0;
      #1;
      check("post_rst_ready1", {31'd0, req1_ready}, 1);
      check("post_rst_ready0", {31'd0, req0_ready}, 0);
      @(negedge clk);
      check("first_owner", {31'd0, owner}, 1);
      check("first_done", {31'd0, done}, 1);
      check("first_busy", {31'd0, busy}, 0);
      req0_valid = 0;
      req1_valid = 0;
      @(negedge clk);
      check("first_idle_done", {31'd0, done}, 0);
      cur = 0;
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);
      // preemption of a req0 ramp by req1 at duty 30
      pulse_reset();
      issue(0, 100, 10);
      for (int i = 1; i <= 3; i++) begin
         repeat (4) @(negedge clk);
         check("pre_ramp", {12'd0, duty_need}, 32'(10 * i));
      end
      check("no_preempt0", {31'd0, req0_ready}, 0);
      issue(1, 0, 15);
      check("pre_owner", {31'd0, owner}, 1);
      check("pre_gap", {22'd0, duty_gap}, 15);
      check("pre_duty", {12'd0, duty_need}, 30);
      check("pre_busy", {31'd0, busy}, 1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("pre_ready0_low", {31'd0, req0_ready}, 0);
         if (c == 4) check("pre_15", {12'd0, duty_need}, 15);
         if (c == 8) begin
            check("pre_0", {12'd0, duty_need}, 0);
            check("pre_done", {31'd0, done}, 1);
         end else begin
            check("pre_no_done", {31'd0, done}, 0);
         end
      end
      @(negedge clk);
      check("pre_done_once", {31'd0, done}, 0);
      check("pre_ready0_idle", {31'd0, req0_ready}, 1);
      // reset in the middle of a ramp
      pulse_reset();
      issue(0, 100, 10);
      repeat (16) @(negedge clk);
      check("mid_40", {12'd0, duty_need}, 40);
      rst = 1;
      @(negedge clk);
      check("mid_duty", {12'd0, duty_need}, 0);
      check("mid_busy", {31'd0, busy}, 0);
      check("mid_done", {31'd0, done}, 0);
      check("mid_gap", {22'd0, duty_gap}, 1);
      check("mid_owner", {31'd0, owner}, 0);
      rst = 0;
      @(negedge clk);
      check("mid_after_done", {31'd0, done}, 0);
      check("mid_after_busy", {31'd0, busy}, 0);
      // saturation near full scale
      issue(1, 20'hFFF00, 10'd1023);
      begin
         int k = 0;
         while (done !== 1'b1 && k < 6000) begin
            @(negedge clk);
            k++;
         end
      end
      check("sat_reach_done", {31'd0, done}, 1);
      check("sat_base", {12'd0, duty_need}, 32'hFFF00);
      @(negedge clk);
      issue(0, 20'hFFFFF, 10'd1023);
      repeat (3) @(negedge clk);
      check("sat_hold", {12'd0, duty_need}, 32'hFFF00);
      @(negedge clk);
      check("sat_top", {12'd0, duty_need}, 32'hFFFFF);
      check("sat_done", {31'd0, done}, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
